multibyte_add_sequencer: RTL and testbench

//  Upstream controller for the registered 8-bit ripple adder wrapper. Accepts one wide operand pair
//  (8*NBYTES bits) over a valid/ready handshake and slices it LSB byte first into the wrapper.

---
 rtl/multibyte_add_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_multibyte_add_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multibyte_add_sequencer.sv
// Drives a wide add through a registered 8-bit adder wrapper one byte at a time, LSB first.
// Optional macro SEQ_SUB_MODE_EN adds in_sub, which computes A - B - in_cin.
module multibyte_add_sequencer #(
   parameter int NBYTES    = 4,
   parameter int ADDER_LAT = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NBYTES-1:0]   in_a,
   input  logic [8*NBYTES-1:0]   in_b,
   input  logic                  in_cin,
`ifdef SEQ_SUB_MODE_EN
   input  logic                  in_sub,
`endif
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [8*NBYTES-1:0]   res_sum,
   output logic                  res_cout,
   output logic                  add_en,
   output logic [7:0]            add_a,
   output logic [7:0]            add_b,
   output logic                  add_cin,
   input  logic [7:0]            add_sum,
   input  logic                  add_cout
);

   localparam int W     = 8 * NBYTES;
   localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int CNT_W = $clog2(ADDER_LAT + 1);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((ADDER_LAT > 1) ? ADDER_LAT - 2 : 0);
   localparam logic [W-1:0]     BYTE_MASK = W'(8'hFF);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPT,
      S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [W-1:0]       op_a, op_a_nxt;
   logic [W-1:0]       op_b, op_b_nxt;
   logic               carry, carry_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
   logic               in_ready_nxt;
   logic               res_valid_nxt;
   logic [W-1:0]       res_sum_nxt;
   logic               res_cout_nxt;
   logic               add_en_nxt;
   logic [7:0]         add_a_nxt;
   logic [7:0]         add_b_nxt;
   logic               add_cin_nxt;

   // Both ports are valid/ready: a transfer happens on a posedge where valid and ready are
   // both high; the sender keeps data stable while valid is high and ready is low.
   always_comb begin
      state_nxt     = state;
      op_a_nxt      = op_a;
      op_b_nxt      = op_b;
      carry_nxt     = carry;
      idx_nxt       = idx;
      wait_cnt_nxt  = wait_cnt;
      in_ready_nxt  = in_ready;
      res_valid_nxt = res_valid;
      res_sum_nxt   = res_sum;
      res_cout_nxt  = res_cout;
      add_en_nxt    = 1'b0;
      add_a_nxt     = add_a;
      add_b_nxt     = add_b;
      add_cin_nxt   = add_cin;

      case (state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               op_a_nxt = in_a;
`ifdef SEQ_SUB_MODE_EN
               // Subtraction reuses the adder: A + ~B + ~cin.
               op_b_nxt  = in_sub ? ~in_b : in_b;
               carry_nxt = in_sub ? ~in_cin : in_cin;
`else
               op_b_nxt  = in_b;
               carry_nxt = in_cin;
`endif
               idx_nxt      = '0;
               in_ready_nxt = 1'b0;
               state_nxt    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ADDER_LAT > 1) begin
               wait_cnt_nxt = WAIT_LOAD;
               state_nxt    = S_WAIT;
            end else begin
               state_nxt = S_CAPT;
            end
         end
         S_WAIT: begin
            if (wait_cnt == '0) begin
               state_nxt = S_CAPT;
            end else begin
               wait_cnt_nxt = wait_cnt - 1'b1;
            end
         end
         S_CAPT: begin
            res_sum_nxt = (res_sum & ~(BYTE_MASK << {idx, 3'b000}))
                        | (W'(add_sum) << {idx, 3'b000});
            carry_nxt   = add_cout;
            if (idx == LAST_IDX) begin
               res_cout_nxt = add_cout;
               state_nxt    = S_DONE;
            end else begin
               idx_nxt   = idx + 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_DONE: begin
            // res_valid is raised one cycle into DONE, so an early res_ready cannot complete it.
            if (!res_valid) begin
               res_valid_nxt = 1'b1;
            end else if (res_ready) begin
               res_valid_nxt = 1'b0;
               in_ready_nxt  = 1'b1;
               state_nxt     = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Wrapper inputs are registered, so they are loaded on the edge that enters ISSUE.
      if (state_nxt == S_ISSUE) begin
         add_en_nxt  = 1'b1;
         add_a_nxt   = 8'(op_a_nxt >> {idx_nxt, 3'b000});
         add_b_nxt   = 8'(op_b_nxt >> {idx_nxt, 3'b000});
         add_cin_nxt = carry_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         op_a      <= '0;
         op_b      <= '0;
         carry     <= 1'b0;
         idx       <= '0;
         wait_cnt  <= '0;
         in_ready  <= 1'b1;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         add_en    <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
         add_cin   <= 1'b0;
      end else begin
         state     <= state_nxt;
         op_a      <= op_a_nxt;
         op_b      <= op_b_nxt;
         carry     <= carry_nxt;
         idx       <= idx_nxt;
         wait_cnt  <= wait_cnt_nxt;
         in_ready  <= in_ready_nxt;
         res_valid <= res_valid_nxt;
         res_sum   <= res_sum_nxt;
         res_cout  <= res_cout_nxt;
         add_en    <= add_en_nxt;
         add_a     <= add_a_nxt;
         add_b     <= add_b_nxt;
         add_cin   <= add_cin_nxt;
      end
   end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Bench for multibyte_add_sequencer: vector table, corner sequences and random ops
// against an arithmetic reference, with a 2-stage 8-bit adder wrapper model.
module tb_multibyte_add_sequencer;

   localparam int NBYTES    = 4;
   localparam int ADDER_LAT = 2;
   localparam int W         = 8 * NBYTES;
   localparam int LAT_EXP   = (ADDER_LAT + 1) * NBYTES + 1;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
   } vec_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_cin = 1'b0;
   logic         in_sub = 1'b0;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [W-1:0] res_sum;
   logic         res_cout;
   logic         add_en;
   logic [7:0]   add_a;
   logic [7:0]   add_b;
   logic         add_cin;
   logic [7:0]   add_sum = '0;
   logic         add_cout = 1'b0;

   int           n_checks = 0;
   int           n_fail = 0;
   int           cyc = 0;
   int           en_q[$];
   logic [W:0]   exp_q[$];
   vec_t         tbl[7];

   multibyte_add_sequencer #(.NBYTES(NBYTES), .ADDER_LAT(ADDER_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
`ifdef SEQ_SUB_MODE_EN
      .in_sub    (in_sub),
`endif
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .add_en    (add_en),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout)
   );

   always #5 clk = ~clk;

   // Adder wrapper model: input register then output register; the result is only valid
   // for the single cycle it is due, otherwise the output carries random junk.
   logic [7:0] w_a = '0;
   logic [7:0] w_b = '0;
   logic       w_cin = 1'b0;
   logic       w_v = 1'b0;
   always @(posedge clk) begin
      w_v <= add_en;
      if (add_en) begin
         w_a   <= add_a;
         w_b   <= add_b;
         w_cin <= add_cin;
      end
      if (w_v) {add_cout, add_sum} <= {1'b0, w_a} + {1'b0, w_b} + 9'(w_cin);
      else     {add_cout, add_sum} <= 9'($urandom);
   end

   // add_en pulse monitor: records the cycle number of every high sample.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (add_en) en_q.push_back(cyc);
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // Reference: plain wide arithmetic, {cout, sum}.
   function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
      logic [W:0] r;
      if (sub) begin
         r[W-1:0] = a - b - W'(cin);
         r[W]     = ({1'b0, a} >= ({1'b0, b} + (W+1)'(cin)));
      end else begin
         r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W:0] exp, input int hold,
                        input bit early, input string tag);
      int         lat;
      logic [W:0] want;
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      lat = 0;
      while (!in_ready && lat < 100) begin
         tick();
         lat++;
      end
      if (!in_ready) begin
         check({tag, "_accept_timeout"}, 64'(in_ready), 64'(1));
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back(exp);
      en_q.delete();
      tick();
      in_valid  = 1'b0;
      res_ready = early;
      lat = 0;
      while (!res_valid && lat < 200) begin
         tick();
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(LAT_EXP));
      repeat (hold) begin
         in_valid = ~in_valid;
         in_a = $urandom;
         in_b = $urandom;
         tick();
         check({tag, "_hold"}, 64'({in_ready, res_valid, res_cout, res_sum}),
               64'({2'b01, exp_q[0]}));
      end
      in_valid = 1'b0;
      want = exp_q.pop_front();
      check({tag, "_result"}, 64'({res_cout, res_sum}), 64'(want));
      check({tag, "_pulses"}, 64'(en_q.size()), 64'(NBYTES));
      for (int i = 1; i < en_q.size(); i++)
         check({tag, "_spacing"}, 64'(en_q[i] - en_q[i-1]), 64'(ADDER_LAT + 1));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({tag, "_release"}, 64'({in_ready, res_valid}), 64'(2'b10));
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      int           h, sent, got, guard;
      bit           acc, hs;

      tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
      tbl[1] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0};
      tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
      tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
      tbl[4] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
      tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
      tbl[6] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0};

      // Reset state
      repeat (3) tick();
      check("rst_ready_valid", 64'({in_ready, res_valid}), 64'(2'b10));
      check("rst_result", 64'({res_cout, res_sum}), 64'(0));
      check("rst_adder_if", 64'({add_en, add_a, add_b, add_cin}), 64'(0));
      reset = 1'b0;
      tick();

      // Vector table; vec0 holds the result 10 cycles while in_valid toggles
      for (int i = 0; i < 7; i++)
         do_op(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, {tbl[i].cout, tbl[i].sum},
               (i == 0) ? 10 : 0, (i == 2), $sformatf("vec%0d", i));

`ifdef SEQ_SUB_MODE_EN
      do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 32'hFFFF_FFFE}, 0, 1'b0, "sub0");
`endif

      // Reset during WAIT of byte 2 aborts the operation
      in_a = $urandom; in_b = $urandom; in_cin = 1'b1; in_sub = 1'b0; in_valid = 1'b1;
      en_q.delete();
      tick();
      in_valid = 1'b0;
      repeat (7) tick();
      check("mid_pulses_before_reset", 64'({en_q.size(), add_en, in_ready}), 64'({32'd3, 2'b00}));
      reset = 1'b1;
      tick();
      check("mid_reset_state", 64'({in_ready, res_valid, res_cout, res_sum, add_en}),
            64'({2'b10, 1'b0, 32'h0, 1'b0}));
      reset = 1'b0;
      ra = $urandom; rb = $urandom;
      do_op(ra, rb, 1'b0, 1'b0, ref_model(ra, rb, 1'b0, 1'b0), 0, 1'b0, "post_reset");

      // Back-to-back with res_ready and in_valid tied high
      res_ready = 1'b1;
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      in_a = ra; in_b = rb; in_cin = rc; in_sub = 1'b0; in_valid = 1'b1;
      sent = 0; got = 0; guard = 0;
      while (got < 3 && guard < 300) begin
         acc = in_valid && in_ready;
         hs  = res_valid && res_ready;
         if (hs) begin
            check($sformatf("b2b_result%0d", got), 64'({res_cout, res_sum}), 64'(exp_q.pop_front()));
            got++;
         end
         if (acc) exp_q.push_back(ref_model(in_a, in_b, in_cin, 1'b0));
         tick();
         guard++;
         if (acc) begin
            sent++;
            if (sent < 3) begin
               in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1));
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      check("b2b_count", 64'(got), 64'(3));
      in_valid = 1'b0;
      res_ready = 1'b0;
      exp_q.delete();
      tick();

      // Random operations against the reference model
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0:       begin ra = '1; rb = 32'($urandom_range(0, 3)); end
            1:       begin ra = $urandom & 32'h00FF_FFFF; rb = 32'h0000_0001; end
            default: begin ra = $urandom; rb = $urandom; end
         endcase
         rc = 1'($urandom_range(0, 1));
`ifdef SEQ_SUB_MODE_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         h = $urandom_range(0, 3);
         do_op(ra, rb, rc, rs, ref_model(ra, rb, rc, rs), h,
               (h == 0) && ($urandom_range(0, 1) == 1), $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
